dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder: one access in flight, IDLE -> (WAIT) -> RESP -> IDLE.
// Optional wait states are compiled in with `define DMEM_WAIT_STATE_EN (WAIT_CYCLES per access).
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        misalign,
   output logic [1:0]  dbg_state_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e state_q, state_d;

   // Handshake: req is sampled only while IDLE; the request is then latched and
   // ack pulses for one cycle in RESP, with rdata/misalign valid alongside ack.
   logic          we_q, we_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          mis_q, mis_d;
   logic [31:0]   rdata_q;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic          mis_in;
   logic [31:0]   rd_word;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_ext;
   logic [3:0]    be;
   logic [31:0]   wd_lane;
   logic          mem_wr;

   logic          unused_addr_bits;
   assign unused_addr_bits = ^addr[31:AW+2];

   assign accept = (state_q == S_IDLE) && req;
   assign mis_in = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
   assign dbg_state_o = state_q;

`ifdef DMEM_WAIT_STATE_EN
   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == S_IDLE) && (state_d == S_WAIT)) begin
         cnt_d = CW'(WAIT_CYCLES - 1);
      end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; misaligned accesses never wait
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
`ifdef DMEM_WAIT_STATE_EN
               state_d = ((WAIT_CYCLES > 0) && !mis_in) ? S_WAIT : S_RESP;
`else
               state_d = S_RESP;
`endif
            end
         end
`ifdef DMEM_WAIT_STATE_EN
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end
         end
`endif
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Load path: asynchronous read of the latched word, then lane select and extension
   always_comb begin
      rd_word = mem_q[idx_q];
      ld_byte = rd_word[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];
      unique case (size_q)
         2'b00:   ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_ext = rd_word;
      endcase
   end

   // Output logic
   always_comb begin
      ack      = 1'b0;
      busy     = 1'b0;
      misalign = 1'b0;
      rdata    = rdata_q;
      unique case (state_q)
         S_WAIT: busy = 1'b1;
         S_RESP: begin
            busy     = 1'b1;
            ack      = 1'b1;
            misalign = mis_q;
            if (mis_q) begin
               rdata = 32'h0;
            end else if (!we_q) begin
               rdata = ld_ext;
            end
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Request capture
   always_comb begin
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      idx_d   = idx_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      mis_d   = mis_q;
      if (accept) begin
         we_d    = we;
         size_d  = size;
         uns_d   = unsigned_ld;
         idx_d   = addr[AW+1:2];
         off_d   = addr[1:0];
         wdata_d = wdata;
         mis_d   = mis_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         idx_q   <= '0;
         off_q   <= 2'b00;
         wdata_q <= 32'h0;
         mis_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         mis_q   <= mis_d;
         if (state_q == S_RESP) begin
            rdata_q <= rdata;
         end
      end
   end

   // Store lanes are replicated so each enabled byte picks its own slice
   always_comb begin
      unique case (size_q)
         2'b00: begin
            be      = 4'b0001 << off_q;
            wd_lane = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be      = off_q[1] ? 4'b1100 : 4'b0011;
            wd_lane = {2{wdata_q[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            wd_lane = wdata_q;
         end
      endcase
   end

   assign mem_wr = !rst && (state_q == S_RESP) && we_q && !mis_q;

   // Array is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
               mem_q[idx_q][8*l +: 8] <= wd_lane[8*l +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: round trips, extension, lane merge, misalign, wrap, req ignore, reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        misalign;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          acks;

`ifdef DMEM_WAIT_STATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // clock / reset
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ack         (ack),
    .busy        (busy),
    .misalign    (misalign),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: one access, measures ack latency in cycles after acceptance
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                        output logic [31:0] rd, output logic mis);
    int lat;
    lat = 0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsigned_ld = uns; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (ack) lat = n;
    end
    rd  = rdata;
    mis = misalign;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_at_ack"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, {31'b0, ack}, 32'd0);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        mis;
    access(tag, 1'b1, sz, 1'b0, a, d, LAT, rd, mis);
    check({tag, "_mis"}, {31'b0, mis}, 32'd0);
    check({tag, "_rdata_held"}, rd, last_rd);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] exp);
    logic [31:0] rd;
    logic        mis;
    exp_q.push_back(exp);
    access(tag, 1'b0, sz, uns, a, 32'h0, LAT, rd, mis);
    check({tag, "_mis"}, {31'b0, mis}, 32'd0);
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    last_rd = exp;
  endtask

  task automatic misacc(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] rd;
    logic        mis;
    access(tag, w, sz, 1'b0, a, d, 1, rd, mis);
    check({tag, "_mis"}, {31'b0, mis}, 32'd1);
    check({tag, "_rdata_zero"}, rd, 32'h0);
    last_rd = 32'h0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0; last_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mis", {31'b0, misalign}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);

    // word round trip; a following store must leave rdata alone
    store("sw10", 2'b10, 32'h10, 32'hDEADBEEF);
    load("lw10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    store("sw60", 2'b10, 32'h60, 32'h600D600D);

    // byte / half extension
    store("sw20", 2'b10, 32'h20, 32'h80FF7F01);
    load("lb22s", 2'b00, 1'b0, 32'h22, 32'hFFFFFFFF);
    load("lh22u", 2'b01, 1'b1, 32'h22, 32'h000080FF);
    load("lb20s", 2'b00, 1'b0, 32'h20, 32'h00000001);
    load("lh20s", 2'b01, 1'b0, 32'h20, 32'h00007F01);
    load("lh22s", 2'b01, 1'b0, 32'h22, 32'hFFFF80FF);
    load("lb23u", 2'b00, 1'b1, 32'h23, 32'h00000080);
    load("lb21s", 2'b00, 1'b0, 32'h21, 32'h0000007F);

    // lane merge
    store("sw30", 2'b10, 32'h30, 32'h00000000);
    store("sb31", 2'b00, 32'h31, 32'h123456AB);
    load("lw30", 2'b10, 1'b0, 32'h30, 32'h0000AB00);
    store("sh32", 2'b01, 32'h32, 32'hFFFF1234);
    load("lw30_sz3", 2'b11, 1'b0, 32'h30, 32'h1234AB00);

    // misalignment
    store("sw40", 2'b10, 32'h40, 32'h11111111);
    misacc("msw41", 1'b1, 2'b10, 32'h41, 32'h22222222);
    misacc("msh41", 1'b1, 2'b01, 32'h41, 32'h3333);
    misacc("mlh43", 1'b0, 2'b01, 32'h43, 32'h0);
    misacc("mlw42", 1'b0, 2'b10, 32'h42, 32'h0);
    load("lw40", 2'b10, 1'b0, 32'h40, 32'h11111111);

    // address wrap modulo 4 KiB
    store("sw1004", 2'b10, 32'h1004, 32'h5A5A5A5A);
    load("lw4", 2'b10, 1'b0, 32'h4, 32'h5A5A5A5A);

    // req held high through WAIT/RESP must not start a second access
    store("sw54", 2'b10, 32'h54, 32'h00000054);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h50; wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 addr = 32'h54; wdata = 32'hFFFFFFFF;
    acks = 0;
    for (int n = 0; n < 20 && acks == 0; n++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    @(posedge clk);
    #1 req = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("req_ignored_acks", 32'(acks), 32'd1);
    load("lw50", 2'b10, 1'b0, 32'h50, 32'h0BADF00D);
    load("lw54", 2'b10, 1'b0, 32'h54, 32'h00000054);

    // reset right after acceptance of a store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ack", {31'b0, ack}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_mis", {31'b0, misalign}, 32'd0);
    check("midrst_rdata", rdata, 32'h0);
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("midrst_no_ack", 32'(acks), 32'd0);
    last_rd = 32'h0;
    load("lw10_after_rst", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

    // req during the reset cycle is dropped
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    @(posedge clk);
    #1 rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rstreq_busy", {31'b0, busy}, 32'd0);
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("rstreq_no_ack", 32'(acks), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
